imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the byte-addressed, little-endian instruction memory.
//  - Accepts 32-bit instruction words on a valid/ready stream.
//  - Writes each word as four byte writes into the memory's byte-wide write port.
//  - Holds the CPU pipeline until the program is resident.
//  - Sits between the testbench/boot source and instruction memory, ahead of the fetch stage.
// PARAMETERS
//  MEM_BYTES  208  instruction memory size in bytes; writes must stay below this
//  ADDR_W     64   width of byte addresses, matching the fetch address width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       one-cycle request to begin a load; sampled only in IDLE
//  base_addr    in   ADDR_W  first byte address; must be 4-byte aligned
//  in_valid     in   1       in_word/in_last valid
//  in_ready     out  1       loader can accept a word this cycle
//  in_word      in   32      instruction word
//  in_last      in   1       marks the final word of the program
//  mem_we       out  1       byte write enable to instruction memory
//  mem_addr     out  ADDR_W  byte address being written
//  mem_wdata    out  8       byte being written
//  cpu_hold     out  1       keeps the pipeline stalled/PC at reset vector while high
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse when a load terminates (normally or by error)
//  err_overflow out  1       sticky; a word would exceed MEM_BYTES
//  err_align    out  1       sticky; start issued with base_addr[1:0] != 0
// BEHAVIOUR
//  Reset:
//   - Async assertion forces IDLE immediately.
//   - Outputs in_ready, mem_we, busy, done, cpu_hold, err_* = 0; mem_addr = 0; mem_wdata = 0.
//   - Bytes already written stay in memory; there is no rollback.
//  State machine:
//   - IDLE:
//     - start with base_addr[1:0]==0: ptr <= base_addr, clear errors, go to ACCEPT.
//     - start with base_addr[1:0]!=0: set err_align, pulse done, stay in IDLE.
//   - ACCEPT:
//     - in_ready = 1.
//     - On in_valid & in_ready: latch word, latch in_last, set byte index k=0.
//       - If ptr+4 > MEM_BYTES: discard the word, set err_overflow, go to FINISH.
//       - Otherwise go to WRITE.
//   - WRITE (4 cycles, k = 0..3):
//     - in_ready = 0, mem_we = 1.
//     - mem_addr = ptr + k; mem_wdata = word[8k+7:8k] (little-endian, so a fetch of
//       {m[a+3],m[a+2],m[a+1],m[a]} returns the word).
//     - After k=3: ptr <= ptr + 4.
//       - If the latched last was set: go to FINISH.
//       - Otherwise go to ACCEPT.
//   - FINISH: done = 1 for one cycle, then go to IDLE.
//  Timing:
//   - First mem_we occurs the cycle after the accepting handshake.
//   - Throughput is one word per 5 cycles.
//  Signal rules:
//   - cpu_hold = busy, registered. It deasserts the same cycle that IDLE is re-entered.
//   - start while busy is ignored.
//   - in_valid while not ready must hold in_word/in_last stable; the loader never drops a word.
//   - ptr arithmetic is ADDR_W wide and unsigned. The overflow test uses the full
//     width, so no wrap-around write is possible.
//   - Exactly filling to MEM_BYTES is legal. Only a word needing a byte at
//     index >= MEM_BYTES is rejected.
//   - err_* remain set until the next accepted start.
// STRUCTURE
//  Shared include (imem_defs.vh):
//   - MEM_BYTES default.
//   - State encodings IDLE/ACCEPT/WRITE/FINISH.
//   - Byte-lane width constant.
//  Optional sub-module: imem_byte_serializer.
//   - Takes a 32-bit word plus base address.
//   - Emits 4 byte writes.
//   - Provides a done flag.
//  Top-level FSM, ptr and errors stay in imem_loader.
// TESTING
//  1. base=0, word 0x00500293 with last=1 -> writes (0,93)(1,02)(2,50)(3,00) on
//     4 consecutive cycles, done pulse, cpu_hold falls.
//  2. Three back-to-back words with in_valid held high -> in_ready low during each
//     4-cycle WRITE, addresses 0..11, no word lost or duplicated.
//  3. base=204, two words (second with last) -> first word written to 204..207;
//     second discarded, err_overflow=1, done pulse, no write at 208.
//  4. base=2 with start -> err_align=1, done pulse, zero mem_we cycles, busy stays 0.
//  5. Assert reset after 2 bytes of a word -> same-instant mem_we=0, busy=0, cpu_hold=0;
//     later start from base 0 reloads cleanly.
//  6. start pulsed during WRITE -> ignored; ptr continues sequentially; load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: sizes, byte lane width, FSM encodings.
// No logic here; imported by the loader top and its byte serializer.
// State encodings are plain 2-bit constants so they read the same in older tooling.
package imem_loader_pkg;

    localparam int MEM_BYTES_DEFAULT = 208;
    localparam int ADDR_W_DEFAULT    = 64;
    localparam int BYTE_W            = 8;
    localparam int WORD_W            = 32;
    localparam int WORD_BYTES        = WORD_W / BYTE_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

endpackage

// File: rtl/imem_byte_serializer.sv
// Splits one latched 32-bit word into four little-endian byte writes at base, base+1, base+2, base+3.
// Latency: byte k is presented in the k-th enabled cycle after load; last_o marks the fourth byte.
// Backpressure: none; the owner holds en_i high for exactly four cycles per loaded word.
module imem_byte_serializer
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BYTE_W-1:0] wdata_o,
    output logic              last_o
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        k_q;

    // Capture the word and restart the byte index on load; step the index while emitting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            k_q    <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            k_q    <= '0;
        end else if (en_i) begin
            k_q <= k_q + 2'd1;
        end
    end

    // Byte lane k goes to base+k; outputs are forced to zero when not emitting.
    always_comb begin
        we_o    = en_i;
        addr_o  = '0;
        wdata_o = '0;
        last_o  = 1'b0;
        if (en_i) begin
            addr_o  = base_i + ADDR_W'(k_q);
            wdata_o = word_q[{k_q, 3'b000} +: BYTE_W];
            last_o  = (k_q == 2'd3);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit program words into the byte-wide instruction memory port and holds the CPU until done.
// Latency: first byte write the cycle after the accepting handshake; one word per 5 cycles.
// Backpressure: in_ready only in ACCEPT; low during the four byte-write cycles of each word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_align
);

    // One extra bit so the end-of-word test cannot wrap around the address space.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last_q, last_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_align_q, err_align_d;
    logic              align_done_q, align_done_d;
    logic              hold_q;
    logic [ADDR_W:0]   word_end;
    logic              accept_hs;
    logic              ser_en;
    logic              ser_last;

    assign word_end  = {1'b0, ptr_q} + (ADDR_W+1)'(WORD_BYTES);
    assign in_ready  = (state_q == S_ACCEPT);
    assign accept_hs = in_ready & in_valid;
    assign ser_en    = (state_q == S_WRITE);

    imem_byte_serializer #(
        .ADDR_W (ADDR_W)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept_hs),
        .en_i    (ser_en),
        .word_i  (in_word),
        .base_i  (ptr_q),
        .we_o    (mem_we),
        .addr_o  (mem_addr),
        .wdata_o (mem_wdata),
        .last_o  (ser_last)
    );

    // Next-state logic: load sequencing, write pointer and sticky error flags.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        last_d       = last_q;
        err_ovf_d    = err_ovf_q;
        err_align_d  = err_align_q;
        align_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (base_addr[1:0] == 2'b00) begin
                        ptr_d       = base_addr;
                        err_ovf_d   = 1'b0;
                        err_align_d = 1'b0;
                        state_d     = S_ACCEPT;
                    end else begin
                        // Rejected start: flag it and report termination without leaving IDLE.
                        err_align_d  = 1'b1;
                        align_done_d = 1'b1;
                    end
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    last_d = in_last;
                    if (word_end > MEM_LIMIT) begin
                        // Word would spill past the end of memory: drop it and end the load.
                        err_ovf_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (ser_last) begin
                    ptr_d   = ptr_q + ADDR_W'(WORD_BYTES);
                    state_d = last_q ? S_FINISH : S_ACCEPT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; cpu_hold tracks the next state so it falls exactly as IDLE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            last_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_align_q  <= 1'b0;
            align_done_q <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            last_q       <= last_d;
            err_ovf_q    <= err_ovf_d;
            err_align_q  <= err_align_d;
            align_done_q <= align_done_d;
            hold_q       <= (state_d != S_IDLE);
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign cpu_hold     = hold_q;
    assign done         = (state_q == S_FINISH) | align_done_q;
    assign err_overflow = err_ovf_q;
    assign err_align    = err_align_q;

endmodule
